// File: rtl/johnson_pkg.sv
// Shared types and helpers for the parametrised Johnson counter and its decoders.
package johnson_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [MAX_WIDTH-1:0] code_t;

    // Thermometer code of a phase: ones fill from bit 0, then zeros fill from bit 0.
    function automatic code_t phase_to_code(input int unsigned width, input int unsigned phase);
        code_t code;
        code = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                if (phase <= width) begin
                    code[i] = (i < phase);
                end else begin
                    code[i] = (i >= phase - width);
                end
            end
        end
        return code;
    endfunction

    // A Johnson code has at most one boundary between adjacent differing bits.
    function automatic logic is_legal_code(input int unsigned width, input code_t code);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i + 1 < MAX_WIDTH; i++) begin
            if ((i + 1 < width) && (code[i] != code[i+1])) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson state decode: binary phase, one-hot phase and legality.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned PW    = $clog2(2*WIDTH),
    localparam int unsigned NPH   = 2*WIDTH,
    localparam int unsigned CW    = PW + 1
) (
    input  logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic [NPH-1:0]   phase_oh,
    output logic             legal
);

    logic [CW-1:0] ones;

    // MSB clear: phase is the ones count; MSB set: phase is 2W minus the ones count.
    always_comb begin
        ones     = '0;
        phase    = '0;
        phase_oh = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ones = ones + CW'(q[i]);
        end
        legal = is_legal_code(WIDTH, code_t'(q));
        if (legal) begin
            phase           = q[WIDTH-1] ? PW'(NPH - 32'(ones)) : PW'(ones);
            phase_oh[phase] = 1'b1;
        end
    end

endmodule

// File: rtl/johnson_counter_param.sv
// Up/down Johnson counter with phase load, decode, terminal count and illegal-state recovery.
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PW    = $clog2(2*WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [PW-1:0]      load_phase,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   q,
    output logic [PW-1:0]      phase,
    output logic [2*WIDTH-1:0] phase_oh,
    output logic               tc,
    output logic               err
);

    localparam int unsigned NPH = 2*WIDTH;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             err_r;
    logic             err_nxt;
    logic             legal;
    logic             load_ok;
    logic             err_set;

    johnson_decode #(.WIDTH(WIDTH)) u_decode (
        .q        (q_r),
        .phase    (phase),
        .phase_oh (phase_oh),
        .legal    (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= '0;
            err_r <= 1'b0;
        end else begin
            q_r   <= q_nxt;
            err_r <= err_nxt;
        end
    end

    // Recovery from an illegal state wins unless a load arrives without en.
    always_comb begin
        q_nxt   = q_r;
        err_nxt = err_r;
        load_ok = (32'(load_phase) < NPH);
        err_set = !legal || (load && !load_ok);

        if (!legal && (en || !load)) begin
            q_nxt = '0;
        end else if (load) begin
            if (load_ok) begin
                q_nxt = WIDTH'(phase_to_code(WIDTH, 32'(load_phase)));
            end
        end else if (en) begin
            if (dir == DIR_UP) begin
                q_nxt = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            end else begin
                q_nxt = {~q_r[0], q_r[WIDTH-1:1]};
            end
        end

        if (err_set) begin
            err_nxt = 1'b1;
        end else if (err_clr) begin
            err_nxt = 1'b0;
        end
    end

    assign q   = q_r;
    assign err = err_r;
    assign tc  = en && legal &&
                 (((dir == DIR_UP)   && (phase == PW'(NPH - 1))) ||
                  ((dir == DIR_DOWN) && (phase == '0)));

endmodule

// File: tb/tb_johnson_counter_param.sv
// Self-checking bench for johnson_counter_param at WIDTH 2, 3, 4 and 8.
module tb_johnson_counter_param;

    logic clk = 1'b0;
    logic rst = 1'b0, en = 1'b0, dir = 1'b1, load = 1'b0, err_clr = 1'b0;
    logic [2:0] lp4 = '0, lp3 = '0;
    logic [1:0] lp2 = '0;
    logic [3:0] lp8 = '0;

    logic [3:0] q4;  logic [2:0] ph4; logic [7:0]  oh4; logic tc4, err4;
    logic [2:0] q3;  logic [2:0] ph3; logic [5:0]  oh3; logic tc3, err3;
    logic [1:0] q2;  logic [1:0] ph2; logic [3:0]  oh2; logic tc2, err2;
    logic [7:0] q8;  logic [3:0] ph8; logic [15:0] oh8; logic tc8, err8;

    logic [3:0] chk_q = '0; logic [2:0] chk_ph; logic [7:0] chk_oh; logic chk_legal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    johnson_counter_param #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_phase(lp4), .err_clr(err_clr), .q(q4), .phase(ph4), .phase_oh(oh4), .tc(tc4), .err(err4));
    johnson_counter_param #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_phase(lp3), .err_clr(err_clr), .q(q3), .phase(ph3), .phase_oh(oh3), .tc(tc3), .err(err3));
    johnson_counter_param #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_phase(lp2), .err_clr(err_clr), .q(q2), .phase(ph2), .phase_oh(oh2), .tc(tc2), .err(err2));
    johnson_counter_param #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_phase(lp8), .err_clr(err_clr), .q(q8), .phase(ph8), .phase_oh(oh8), .tc(tc8), .err(err8));

    johnson_decode #(.WIDTH(4)) u_chk (.q(chk_q), .phase(chk_ph), .phase_oh(chk_oh), .legal(chk_legal));

    // Reference: thermometer code of phase p for a w-bit ring.
    function automatic int code_of(input int w, input int p);
        if (p <= w) return (1 << p) - 1;
        return ((1 << w) - 1) ^ ((1 << (p - w)) - 1);
    endfunction

    function automatic bit tc_of(input int w, input int p, input bit e, input bit d);
        return e && (d ? (p == 2*w - 1) : (p == 0));
    endfunction

    function automatic void model_step(input int w, input bit r, input bit e, input bit d, input bit l,
                                       input int lp, input bit ec, inout int p, inout bit er);
        if (r) begin
            p  = 0;
            er = 1'b0;
            return;
        end
        if (l) begin
            if (lp < 2*w) p = lp;
        end else if (e) begin
            p = d ? (p + 1) % (2*w) : (p + 2*w - 1) % (2*w);
        end
        if (l && lp >= 2*w) er = 1'b1;
        else if (ec)        er = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; err_clr = 1'b0; dir = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; dir = 1'b1; err_clr = 1'b0; lp4 = 3'd5;
        tick();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        #1;
        total++;
        if (q4 !== 4'b0000 || ph4 !== 3'd0 || oh4 !== 8'b0000_0001 || err4 !== 1'b0 || tc4 !== 1'b0) begin
            bad++;
            $display("FAIL reset: got q=%b ph=%0d oh=%b err=%b tc=%b want q=0000 ph=0 oh=00000001 err=0 tc=0",
                     q4, ph4, oh4, err4, tc4);
        end
        en = 1'b1; dir = 1'b0;
        #1;
        total++;
        if (tc4 !== 1'b1) begin
            bad++;
            $display("FAIL reset_tc_down: got tc=%b want 1", tc4);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q [9];
        exp_q = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset();
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            total++;
            if (q4 !== exp_q[i] || tc4 !== (i == 7) || oh4 !== 8'(1 << (i % 8)) || ph4 !== 3'(i % 8)) begin
                bad++;
                $display("FAIL count_up step %0d: got q=%b tc=%b oh=%b ph=%0d want q=%b tc=%b oh=%b ph=%0d",
                         i, q4, tc4, oh4, ph4, exp_q[i], (i == 7), 8'(1 << (i % 8)), i % 8);
            end
            tick();
        end
    endtask

    task automatic test_count_down_and_toggle();
        logic [3:0] exp_q [6];
        exp_q = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111};
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (q4 !== exp_q[i] || tc4 !== (i == 0)) begin
                bad++;
                $display("FAIL count_down step %0d: got q=%b tc=%b want q=%b tc=%b", i, q4, tc4, exp_q[i], (i == 0));
            end
            if (i < 5) tick();
        end
        dir = 1'b1;
        tick();
        total++;
        if (q4 !== 4'b1111) begin
            bad++;
            $display("FAIL toggle_up: got q=%b want 1111", q4);
        end
        dir = 1'b0;
        tick();
        total++;
        if (q4 !== 4'b0111) begin
            bad++;
            $display("FAIL toggle_down: got q=%b want 0111", q4);
        end
        tick();
        total++;
        if (q4 !== 4'b0011) begin
            bad++;
            $display("FAIL toggle_down2: got q=%b want 0011", q4);
        end
    endtask

    task automatic test_load();
        do_reset();
        en = 1'b1; load = 1'b1; lp4 = 3'd5; lp3 = 3'd5;
        tick();
        load = 1'b0; en = 1'b0;
        #1;
        total++;
        if (q4 !== 4'b1110 || ph4 !== 3'd5 || q3 !== 3'b100 || ph3 !== 3'd5) begin
            bad++;
            $display("FAIL load5: got q4=%b ph4=%0d q3=%b ph3=%0d want q4=1110 ph4=5 q3=100 ph3=5", q4, ph4, q3, ph3);
        end
        load = 1'b1; en = 1'b1; lp3 = 3'd6;
        tick();
        load = 1'b0; en = 1'b0;
        #1;
        total++;
        if (q3 !== 3'b100 || err3 !== 1'b1 || err4 !== 1'b0) begin
            bad++;
            $display("FAIL bad_load: got q3=%b err3=%b err4=%b want q3=100 err3=1 err4=0", q3, err3, err4);
        end
        load = 1'b1; lp3 = 3'd7; err_clr = 1'b1;
        tick();
        total++;
        if (err3 !== 1'b1) begin
            bad++;
            $display("FAIL err_set_wins: got err3=%b want 1", err3);
        end
        load = 1'b0;
        tick();
        err_clr = 1'b0;
        total++;
        if (err3 !== 1'b0 || q3 !== 3'b100) begin
            bad++;
            $display("FAIL err_clr: got err3=%b q3=%b want err3=0 q3=100", err3, q3);
        end
    endtask

    task automatic test_decoder();
        for (int c = 0; c < 16; c++) begin
            int  want_p;
            bit  want_legal;
            want_p     = 0;
            want_legal = 1'b0;
            for (int p = 0; p < 8; p++) begin
                if (code_of(4, p) == c) begin
                    want_p     = p;
                    want_legal = 1'b1;
                end
            end
            chk_q = 4'(c);
            #1;
            total++;
            if (chk_legal !== want_legal || chk_ph !== 3'(want_p) ||
                chk_oh !== (want_legal ? 8'(1 << want_p) : 8'h00)) begin
                bad++;
                $display("FAIL decode %b: got legal=%b ph=%0d oh=%b want legal=%b ph=%0d", chk_q, chk_legal,
                         chk_ph, chk_oh, want_legal, want_p);
            end
        end
    endtask

    task automatic test_illegal_and_rst_override();
        do_reset();
        en = 1'b1; dir = 1'b1;
        force dut4.q_r = 4'b0101;
        #1;
        total++;
        if (oh4 !== 8'h00 || ph4 !== 3'd0 || tc4 !== 1'b0) begin
            bad++;
            $display("FAIL illegal_decode: got oh=%b ph=%0d tc=%b want oh=00000000 ph=0 tc=0", oh4, ph4, tc4);
        end
        release dut4.q_r;
        tick();
        total++;
        if (q4 !== 4'b0000 || err4 !== 1'b1) begin
            bad++;
            $display("FAIL illegal_fix: got q=%b err=%b want q=0000 err=1", q4, err4);
        end
        force dut4.q_r = 4'b0101;
        #1;
        release dut4.q_r;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (q4 !== 4'b0000 || err4 !== 1'b1) begin
            bad++;
            $display("FAIL illegal_vs_clr: got q=%b err=%b want q=0000 err=1", q4, err4);
        end
        force dut4.q_r = 4'b0100;
        #1;
        release dut4.q_r;
        en = 1'b0; load = 1'b1; lp4 = 3'd6;
        tick();
        load = 1'b0;
        #1;
        total++;
        if (q4 !== 4'b1100 || ph4 !== 3'd6 || err4 !== 1'b1) begin
            bad++;
            $display("FAIL illegal_load: got q=%b ph=%0d err=%b want q=1100 ph=6 err=1", q4, ph4, err4);
        end
        rst = 1'b1; load = 1'b1; en = 1'b1; lp4 = 3'd3;
        tick();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        #1;
        total++;
        if (q4 !== 4'b0000 || err4 !== 1'b0 || ph4 !== 3'd0) begin
            bad++;
            $display("FAIL rst_override: got q=%b err=%b ph=%0d want q=0000 err=0 ph=0", q4, err4, ph4);
        end
    endtask

    task automatic test_wrap_widths();
        do_reset();
        en = 1'b1; dir = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            #1;
            total++;
            if (q2 !== 2'(code_of(2, i % 4)) || ph2 !== 2'(i % 4) || tc2 !== (i % 4 == 3) ||
                q8 !== 8'(code_of(8, i % 16)) || ph8 !== 4'(i % 16) || tc8 !== (i % 16 == 15)) begin
                bad++;
                $display("FAIL wrap step %0d: got q2=%b ph2=%0d tc2=%b q8=%b ph8=%0d tc8=%b want q2=%b q8=%b",
                         i, q2, ph2, tc2, q8, ph8, tc8, 2'(code_of(2, i % 4)), 8'(code_of(8, i % 16)));
            end
            if (i < 16) tick();
        end
    endtask

    task automatic test_random();
        int p4 = 0;
        int p3 = 0;
        bit e4 = 1'b0;
        bit e3 = 1'b0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit r, e, d, l, c;
            int l4, l3;
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 3) == 0);
            l4 = int'($urandom_range(0, 7));
            l3 = int'($urandom_range(0, 7));
            rst = r; en = e; dir = d; load = l; err_clr = c; lp4 = 3'(l4); lp3 = 3'(l3);
            #1;
            total++;
            if (q4 !== 4'(code_of(4, p4)) || ph4 !== 3'(p4) || oh4 !== 8'(1 << p4) ||
                tc4 !== tc_of(4, p4, e, d) || err4 !== e4) begin
                bad++;
                $display("FAIL rand_w4 cyc %0d: got q=%b ph=%0d tc=%b err=%b want q=%b ph=%0d tc=%b err=%b",
                         i, q4, ph4, tc4, err4, 4'(code_of(4, p4)), p4, tc_of(4, p4, e, d), e4);
            end
            total++;
            if (q3 !== 3'(code_of(3, p3)) || ph3 !== 3'(p3) || oh3 !== 6'(1 << p3) ||
                tc3 !== tc_of(3, p3, e, d) || err3 !== e3) begin
                bad++;
                $display("FAIL rand_w3 cyc %0d: got q=%b ph=%0d tc=%b err=%b want q=%b ph=%0d tc=%b err=%b",
                         i, q3, ph3, tc3, err3, 3'(code_of(3, p3)), p3, tc_of(3, p3, e, d), e3);
            end
            model_step(4, r, e, d, l, l4, c, p4, e4);
            model_step(3, r, e, d, l, l3, c, p3, e3);
            tick();
        end
        rst = 1'b0; en = 1'b0; load = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_count_up();
        test_count_down_and_toggle();
        test_load();
        test_decoder();
        test_illegal_and_rst_override();
        test_wrap_widths();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
